// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared encodings for the fetch stage
package if_stage_pkg;
  typedef enum logic [1:0] {NPC_SEQ = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11} npc_op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FETCH = 2'b01, S_HOLD = 2'b10} state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/if_stage_npc_calc.sv
// if_stage_npc_calc: control-transfer target select from the IF/ID contents
module if_stage_npc_calc
  import if_stage_pkg::*;
(
  input  logic [1:0]  npc_op_i,
  input  logic [31:0] pc4_i,
  input  logic [25:0] instr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] target_o
);
  always_comb
    target_o = npc_op_i == NPC_BR ? pc4_i + {{14{instr_i[15]}}, instr_i[15:0], 2'b00} :
               npc_op_i == NPC_J  ? {pc4_i[31:28], instr_i, 2'b00} :
               npc_op_i == NPC_JR ? jr_target_i & ~32'h3 : pc4_i;
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with IF/ID register, one-word skid and delay-slot redirect
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nostall,
  input  logic [1:0]  npc_op,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, skid_q, skid_d, skid_pc4_q, skid_pc4_d, redir_pc_q, redir_pc_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d, pc_plus4, target;
  logic skid_full_q, skid_full_d, pend_q, pend_d, valid_q, valid_d, done, xfer;

  if_stage_npc_calc u_npc (
    .npc_op_i   (npc_op),
    .pc4_i      (pc4_q),
    .instr_i    (instr_q[25:0]),
    .jr_target_i(jr_target),
    .target_o   (target)
  );

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    done = state_q == S_FETCH && imem_ready;
    xfer = nostall && valid_q && npc_op != NPC_SEQ;
    state_d = state_q == S_IDLE ? S_FETCH :
              state_q == S_FETCH ? (done && !nostall ? S_HOLD : S_FETCH) :
              (nostall ? S_FETCH : S_HOLD);
    skid_d = done && !nostall ? imem_rdata : skid_q;
    skid_pc4_d = done && !nostall ? pc_plus4 : skid_pc4_q;
    skid_full_d = done && !nostall ? 1'b1 : nostall ? 1'b0 : skid_full_q;
    instr_d = !nostall ? instr_q : skid_full_q ? skid_q : done ? imem_rdata : NOP_INSTR;
    pc4_d = !nostall ? pc4_q : skid_full_q ? skid_pc4_q : done ? pc_plus4 : pc4_q;
    valid_d = nostall ? skid_full_q || done : valid_q;
    pc_d = !done ? pc_q : pend_q ? redir_pc_q : xfer ? target : pc_plus4;
    pend_d = done ? 1'b0 : pend_q;
    redir_pc_d = redir_pc_q;
    if (xfer && !done) begin
      if (skid_full_q) pc_d = target;
      else begin
        pend_d = 1'b1;
        redir_pc_d = target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      skid_q <= NOP_INSTR;
      skid_pc4_q <= '0;
      skid_full_q <= 1'b0;
      redir_pc_q <= '0;
      pend_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      skid_q <= skid_d;
      skid_pc4_q <= skid_pc4_d;
      skid_full_q <= skid_full_d;
      redir_pc_q <= redir_pc_d;
      pend_q <= pend_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req = state_q == S_FETCH;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4 = pc4_q;
  assign if_id_valid = valid_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a program-order fetch model
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nostall = 1'b0;
  logic [1:0] npc_op = 2'b00;
  logic [31:0] jr_target = '0;
  logic [31:0] imem_rdata = '0;
  logic imem_ready = 1'b0;
  logic imem_req, if_id_valid;
  logic [31:0] imem_addr, pc, if_id_instr, if_id_pc4;
  int checks = 0;
  int errors = 0;
  logic [31:0] prog [logic [31:0]];

  if_stage dut (
    .clk(clk), .rst(rst), .nostall(nostall), .npc_op(npc_op), .jr_target(jr_target),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    if (prog.exists(a)) return prog[a];
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    case (h[31:29])
      3'd0: return {6'd4, h[25:0]};
      3'd1: return {6'd2, h[25:0]};
      3'd2: return {6'd0, h[25:21], 15'd0, 6'd8};
      default: return {6'd0, h[25:6], 6'h21};
    endcase
  endfunction

  task automatic tick();
    imem_rdata = imem_ready ? word_at(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nostall = 1'b0;
    npc_op = 2'b00;
    jr_target = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nostall = 1'b1;
    imem_ready = 1'b1;
    npc_op = 2'b11;
    jr_target = 32'hFFFF_FFFF;
    imem_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, pc} !== {2'b00, 64'h0, 32'h3000}) begin
      errors++;
      $display("FAIL reset_state: got req=%b v=%b i=%h p4=%h pc=%h, expected req=0 v=0 i=0 p4=0 pc=3000",
               imem_req, if_id_valid, if_id_instr, if_id_pc4, pc);
    end
  endtask

  task automatic test_sequential();
    prog.delete();
    do_reset();
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_idle: got req=%b expected 0", imem_req); end
    nostall = 1'b1;
    imem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h3000, 1'b0}) begin
      errors++; $display("FAIL seq_first: got req=%b addr=%h v=%b expected 1 3000 0", imem_req, imem_addr, if_id_valid);
    end
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_pc4, if_id_instr} !== {32'h3004, 1'b1, 32'h3004, word_at(32'h3000)}) begin
      errors++; $display("FAIL seq_second: got addr=%h v=%b p4=%h i=%h expected 3004 1 3004 %h",
                         imem_addr, if_id_valid, if_id_pc4, if_id_instr, word_at(32'h3000));
    end
    tick();
    checks++;
    if ({imem_addr, if_id_pc4} !== {32'h3008, 32'h3008}) begin
      errors++; $display("FAIL seq_third: got addr=%h p4=%h expected 3008 3008", imem_addr, if_id_pc4);
    end
  endtask

  task automatic test_branch();
    prog.delete();
    prog[32'h3000] = 32'h1000_0004;
    do_reset();
    nostall = 1'b1;
    imem_ready = 1'b1;
    tick();
    checks++;
    if (imem_addr !== 32'h3000) begin errors++; $display("FAIL br_f0: got addr=%h expected 3000", imem_addr); end
    tick();
    checks++;
    if ({imem_addr, if_id_instr} !== {32'h3004, 32'h1000_0004}) begin
      errors++; $display("FAIL br_f1: got addr=%h i=%h expected 3004 10000004", imem_addr, if_id_instr);
    end
    npc_op = 2'b01;
    tick();
    npc_op = 2'b00;
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== {32'h3014, 1'b1, word_at(32'h3004), 32'h3008}) begin
      errors++; $display("FAIL br_delay_slot: got addr=%h v=%b i=%h p4=%h expected 3014 1 %h 3008",
                         imem_addr, if_id_valid, if_id_instr, if_id_pc4, word_at(32'h3004));
    end
    tick();
    checks++;
    if ({imem_addr, if_id_instr, if_id_pc4} !== {32'h3018, word_at(32'h3014), 32'h3018}) begin
      errors++; $display("FAIL br_target: got addr=%h i=%h p4=%h expected 3018 %h 3018",
                         imem_addr, if_id_instr, if_id_pc4, word_at(32'h3014));
    end
  endtask

  task automatic test_jump_wait();
    prog.delete();
    prog[32'h3000] = 32'h0810_0000;
    do_reset();
    nostall = 1'b1;
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    npc_op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      npc_op = 2'($urandom);
      jr_target = $urandom;
      checks++;
      if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h3004, 1'b0}) begin
        errors++; $display("FAIL j_wait%0d: got req=%b addr=%h v=%b expected 1 3004 0", i, imem_req, imem_addr, if_id_valid);
      end
    end
    npc_op = 2'b00;
    imem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_addr, if_id_instr, if_id_pc4} !== {32'h0040_0000, word_at(32'h3004), 32'h3008}) begin
      errors++; $display("FAIL j_target: got addr=%h i=%h p4=%h expected 00400000 %h 3008",
                         imem_addr, if_id_instr, if_id_pc4, word_at(32'h3004));
    end
  endtask

  task automatic test_stall();
    prog.delete();
    do_reset();
    nostall = 1'b1;
    imem_ready = 1'b1;
    tick();
    tick();
    nostall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({imem_req, pc, if_id_valid, if_id_instr, if_id_pc4} !== {1'b0, 32'h3008, 1'b1, word_at(32'h3000), 32'h3004}) begin
        errors++; $display("FAIL stall_hold%0d: got req=%b pc=%h v=%b i=%h p4=%h expected 0 3008 1 %h 3004",
                           i, imem_req, pc, if_id_valid, if_id_instr, if_id_pc4, word_at(32'h3000));
      end
    end
    nostall = 1'b1;
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, 32'h3008, 1'b1, word_at(32'h3004), 32'h3008}) begin
      errors++; $display("FAIL stall_release: got req=%b addr=%h v=%b i=%h p4=%h expected 1 3008 1 %h 3008",
                         imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, word_at(32'h3004));
    end
  endtask

  task automatic test_jr();
    prog.delete();
    do_reset();
    nostall = 1'b1;
    imem_ready = 1'b1;
    tick();
    tick();
    npc_op = 2'b11;
    jr_target = 32'h0000_3103;
    tick();
    npc_op = 2'b00;
    checks++;
    if ({imem_addr, if_id_instr} !== {32'h3100, word_at(32'h3004)}) begin
      errors++; $display("FAIL jr_target: got addr=%h i=%h expected 3100 %h", imem_addr, if_id_instr, word_at(32'h3004));
    end
  endtask

  task automatic test_reset_mid_wait();
    prog.delete();
    do_reset();
    nostall = 1'b1;
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, pc} !== {2'b00, 64'h0, 32'h3000}) begin
      errors++; $display("FAIL rst_async: got req=%b v=%b i=%h p4=%h pc=%h expected 0 0 0 0 3000",
                         imem_req, if_id_valid, if_id_instr, if_id_pc4, pc);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_idle: got req=%b expected 0", imem_req); end
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h3000, 1'b0}) begin
      errors++; $display("FAIL rst_refetch: got req=%b addr=%h v=%b expected 1 3000 0", imem_req, imem_addr, if_id_valid);
    end
    tick();
    checks++;
    if ({imem_addr, if_id_instr, if_id_pc4} !== {32'h3004, word_at(32'h3000), 32'h3004}) begin
      errors++; $display("FAIL rst_first_word: got addr=%h i=%h p4=%h expected 3004 %h 3004",
                         imem_addr, if_id_instr, if_id_pc4, word_at(32'h3000));
    end
  endtask

  task automatic test_random();
    logic [31:0] next_fetch, cur_addr, cur_instr, exp_instr, exp_pc4, prev_addr, pend_after, pend_t, t;
    logic [31:0] q [$];
    logic [1:0] op;
    bit exp_valid, last_xfer, pend, prev_wait;
    int off;
    prog.delete();
    do_reset();
    next_fetch = 32'h3000;
    cur_addr = '0;
    cur_instr = '0;
    exp_valid = 1'b0;
    exp_instr = '0;
    exp_pc4 = '0;
    last_xfer = 1'b0;
    pend = 1'b0;
    prev_wait = 1'b0;
    prev_addr = '0;
    pend_after = '0;
    pend_t = '0;
    for (int n = 0; n < 3000; n++) begin
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc4} !== {exp_valid, exp_instr, exp_pc4}) begin
        errors++; $display("FAIL rand_ifid cycle %0d: got v=%b i=%h p4=%h expected v=%b i=%h p4=%h",
                           n, if_id_valid, if_id_instr, if_id_pc4, exp_valid, exp_instr, exp_pc4);
      end
      checks++;
      if (imem_addr[1:0] !== 2'b00 || imem_addr !== pc) begin
        errors++; $display("FAIL rand_addr cycle %0d: got addr=%h pc=%h expected aligned and equal", n, imem_addr, pc);
      end
      if (prev_wait) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
          errors++; $display("FAIL rand_stable cycle %0d: got req=%b addr=%h expected 1 %h", n, imem_req, imem_addr, prev_addr);
        end
      end
      if (q.size() != 0) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rand_hold cycle %0d: got req=%b expected 0", n, imem_req); end
      end
      nostall = $urandom_range(3) != 0;
      imem_ready = $urandom_range(4) < 3;
      jr_target = $urandom;
      npc_op = 2'($urandom);
      if (nostall && exp_valid) begin
        op = 2'b00;
        t = '0;
        if (!last_xfer) begin
          if (cur_instr[31:26] == 6'd4 && $urandom_range(1) == 1) begin
            op = 2'b01;
            off = $signed(cur_instr[15:0]);
            t = cur_addr + 4 + 32'(off * 4);
          end else if (cur_instr[31:26] == 6'd2) begin
            op = 2'b10;
            t = ((cur_addr + 4) & 32'hF000_0000) + 32'(cur_instr[25:0]) * 4;
          end else if (cur_instr[31:26] == 6'd0 && cur_instr[5:0] == 6'd8) begin
            op = 2'b11;
            t = jr_target - (jr_target % 4);
          end
        end
        npc_op = op;
        last_xfer = op != 2'b00;
        if (last_xfer) begin
          if (next_fetch == cur_addr + 8) next_fetch = t;
          else begin
            pend = 1'b1;
            pend_after = cur_addr + 4;
            pend_t = t;
          end
        end
      end
      if (imem_req && imem_ready) begin
        checks++;
        if (imem_addr !== next_fetch) begin
          errors++; $display("FAIL rand_fetch cycle %0d: got addr=%h expected %h", n, imem_addr, next_fetch);
        end
        q.push_back(next_fetch);
        if (pend && next_fetch == pend_after) begin
          next_fetch = pend_t;
          pend = 1'b0;
        end else next_fetch = next_fetch + 4;
      end
      if (nostall) begin
        if (q.size() != 0) begin
          cur_addr = q.pop_front();
          cur_instr = word_at(cur_addr);
          exp_valid = 1'b1;
          exp_instr = cur_instr;
          exp_pc4 = cur_addr + 4;
        end else begin
          exp_valid = 1'b0;
          exp_instr = '0;
        end
      end
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_wait();
    test_stall();
    test_jr();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
